// File: rtl/dac_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// dac_pkg : shared types, widths and ramp helper for the DAC scheduler
// Rev 1.0
// ------------------------------------------------------------------
package dac_pkg;

  localparam int SAMPLE_W          = 16;
  localparam int RAMP_STEP_DEFAULT = 256;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_MUTING = 2'd2,
    S_MUTED  = 2'd3
  } state_e;

  // One ramp step toward zero; the extra bit keeps -32768 from wrapping.
  function automatic logic signed [SAMPLE_W-1:0] ramp_toward_zero(
    input logic signed [SAMPLE_W-1:0] value,
    input logic        [SAMPLE_W-1:0] step
  );
    logic signed [SAMPLE_W:0] v_ext;
    logic signed [SAMPLE_W:0] s_ext;
    logic signed [SAMPLE_W:0] r_ext;
    v_ext = {value[SAMPLE_W-1], value};
    s_ext = {1'b0, step};
    if (v_ext > s_ext)
      r_ext = v_ext - s_ext;
    else if (v_ext < -s_ext)
      r_ext = v_ext + s_ext;
    else
      r_ext = '0;
    return r_ext[SAMPLE_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/sample_fifo.sv
`default_nettype none
// ------------------------------------------------------------------
// sample_fifo : synchronous sample FIFO with registered full/empty
// Rev 1.0
// ------------------------------------------------------------------
module sample_fifo
  import dac_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = SAMPLE_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   c_LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   c_LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] c_PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic [AW:0]      w_level_nxt;
  logic             r_full;
  logic             r_empty;
  logic             w_push;
  logic             w_pop;

  assign w_push = push && !r_full;
  assign w_pop  = pop && !r_empty;

  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop)
      w_level_nxt = r_level + c_LVL_ONE;
    else if (w_pop && !w_push)
      w_level_nxt = r_level - c_LVL_ONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == c_LVL_FULL);
      r_empty <= (w_level_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush)
      r_mem[r_wr_ptr] <= din;
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = r_full;
  assign empty = r_empty;
  assign level = r_level;

endmodule
`default_nettype wire

// File: rtl/dac_sample_sched.sv
`default_nettype none
// ------------------------------------------------------------------
// dac_sample_sched : paced FIFO-to-DAC sample scheduler with mute ramp
// Rev 1.0
// ------------------------------------------------------------------
module dac_sample_sched
  import dac_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int DIV_W     = 16,
  parameter int RAMP_STEP = RAMP_STEP_DEFAULT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        mute,
  input  logic [DIV_W-1:0]            rate_div,
  input  logic signed [SAMPLE_W-1:0]  s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic signed [SAMPLE_W-1:0]  dac_din,
  output logic [$clog2(DEPTH):0]      fifo_level,
  output logic                        underrun,
  input  logic                        underrun_clr
);

  localparam logic [SAMPLE_W-1:0] c_RAMP_STEP = SAMPLE_W'(RAMP_STEP);
  localparam logic [DIV_W-1:0]    c_CNT_ONE   = DIV_W'(1);

  state_e                      r_state;
  logic [DIV_W-1:0]            r_cnt;
  logic [DIV_W-1:0]            r_period;
  logic signed [SAMPLE_W-1:0]  r_dac;
  logic                        r_underrun;
  logic signed [SAMPLE_W-1:0]  w_head;
  logic signed [SAMPLE_W-1:0]  w_ramped;
  logic                        w_full;
  logic                        w_empty;
  logic                        w_idle;
  logic                        w_tick;
  logic                        w_serve;
  logic                        w_pop;
  logic                        w_push;

  assign w_idle   = (r_state == S_IDLE);
  assign w_tick   = !w_idle && (r_cnt == r_period);
  // A tick with mute released serves the FIFO, whether in RUN or leaving a mute.
  assign w_serve  = w_tick && !mute;
  assign w_pop    = w_serve && !w_empty;
  assign s_ready  = !w_idle && !w_full;
  assign w_push   = s_valid && s_ready;
  assign w_ramped = ramp_toward_zero(r_dac, c_RAMP_STEP);

  sample_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (w_idle),
    .push  (w_push),
    .pop   (w_pop),
    .din   (s_data),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .level (fifo_level)
  );

  // The period register only reloads at wrap so a mid-period change waits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_period <= '0;
    end else if (w_idle || w_tick) begin
      r_cnt    <= '0;
      r_period <= rate_div;
    end else begin
      r_cnt    <= r_cnt + c_CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_dac   <= '0;
    end else begin
      if (w_pop)
        r_dac <= w_head;
      else if ((r_state == S_MUTING) && mute && w_tick)
        r_dac <= w_ramped;

      if (!enable) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE:   r_state <= S_RUN;
          S_RUN:    if (mute) r_state <= S_MUTING;
          S_MUTING: begin
            if (w_serve)
              r_state <= S_RUN;
            else if (mute && ((r_dac == '0) || (w_tick && (w_ramped == '0))))
              r_state <= S_MUTED;
          end
          S_MUTED:  if (w_serve) r_state <= S_RUN;
          default:  r_state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_underrun <= 1'b0;
    else if (w_serve && w_empty)
      r_underrun <= 1'b1;
    else if (underrun_clr)
      r_underrun <= 1'b0;
  end

  assign dac_din  = r_dac;
  assign underrun = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_dac_sample_sched.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_dac_sample_sched : directed self-checking bench for dac_sample_sched
// Rev 1.0
// ------------------------------------------------------------------
module tb_dac_sample_sched;

  logic               clk = 1'b0;
  logic               reset;
  logic               enable;
  logic               mute;
  logic [15:0]        rate_div;
  logic signed [15:0] s_data;
  logic               s_valid;
  logic               s_ready;
  logic signed [15:0] dac_din;
  logic [4:0]         fifo_level;
  logic               underrun;
  logic               underrun_clr;

  int n_checks = 0;
  int n_fail   = 0;

  dac_sample_sched #(
    .DEPTH     (16),
    .DIV_W     (16),
    .RAMP_STEP (256)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .mute         (mute),
    .rate_div     (rate_div),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .dac_din      (dac_din),
    .fifo_level   (fifo_level),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int vals [6];
    int ramp [4];
    vals = '{11, 22, 33, -5000, 55, 66};
    ramp = '{744, 488, 232, 0};

    reset = 1'b1; enable = 1'b0; mute = 1'b0; rate_div = '0;
    s_data = '0; s_valid = 1'b0; underrun_clr = 1'b0;
    step(3);
    check("rst_dac",      int'(dac_din),    0);
    check("rst_s_ready",  int'(s_ready),    0);
    check("rst_level",    int'(fifo_level), 0);
    check("rst_underrun", int'(underrun),   0);
    reset = 1'b0;
    step(1);

    // rate_div=3: stream 0..700, one pop every 4 cycles
    rate_div = 16'd3; enable = 1'b1;
    step(1);
    for (int e = 2; e <= 33; e++) begin
      s_valid = (e <= 9);
      s_data  = 16'(100 * (e - 2));
      step(1);
      if (e >= 5 && (e - 5) % 4 == 0)
        check($sformatf("pace_tick_e%0d", e), int'(dac_din), 100 * ((e - 5) / 4));
      if (e >= 8 && e % 4 == 0)
        check($sformatf("pace_hold_e%0d", e), int'(dac_din), 100 * ((e - 8) / 4));
      if (e == 9)
        check("pace_level", int'(fifo_level), 6);
    end
    check("drained_level", int'(fifo_level), 0);
    check("no_underrun",   int'(underrun),   0);

    // underrun on empty tick, clear, and set-wins-over-clear
    step(3);
    check("underrun_pre", int'(underrun), 0);
    step(1);
    check("underrun_set", int'(underrun), 1);
    check("underrun_dac", int'(dac_din),  700);
    underrun_clr = 1'b1;
    step(1);
    check("underrun_clr", int'(underrun), 0);
    underrun_clr = 1'b0;
    step(2);
    underrun_clr = 1'b1;
    step(1);
    check("underrun_setwins", int'(underrun), 1);
    step(1);
    check("underrun_clr2", int'(underrun), 0);
    underrun_clr = 1'b0;

    // IDLE flushes, blocks producer, holds output
    enable = 1'b0;
    step(2);
    check("idle_s_ready", int'(s_ready),    0);
    check("idle_level",   int'(fifo_level), 0);
    check("idle_dac",     int'(dac_din),    700);

    // fill to 16, 17th held off until after a pop
    rate_div = 16'd40; enable = 1'b1;
    step(1);
    s_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_data = 16'(1000 + i);
      step(1);
    end
    check("full_level",   int'(fifo_level), 16);
    check("full_s_ready", int'(s_ready),    0);
    s_data = 16'(9999);
    step(24);
    check("full_wait_level", int'(fifo_level), 16);
    check("full_wait_ready", int'(s_ready),    0);
    step(1);
    check("full_pop_level", int'(fifo_level), 15);
    check("full_pop_ready", int'(s_ready),    1);
    check("full_pop_dac",   int'(dac_din),    1000);
    step(1);
    check("full_refill_level", int'(fifo_level), 16);
    check("full_refill_ready", int'(s_ready),    0);

    // mute ramp 1000 -> 0, then unmute pops next sample
    s_valid = 1'b0; mute = 1'b1; rate_div = 16'd0;
    step(1);
    check("mute_enter_dac", int'(dac_din), 1000);
    step(38);
    check("mute_frozen_dac",   int'(dac_din),    1000);
    check("mute_frozen_level", int'(fifo_level), 16);
    for (int k = 0; k < 4; k++) begin
      step(1);
      check($sformatf("ramp_%0d", k), int'(dac_din), ramp[k]);
    end
    step(1);
    check("muted_hold", int'(dac_din), 0);
    mute = 1'b0;
    step(1);
    check("unmute_dac",   int'(dac_din),    1001);
    check("unmute_level", int'(fifo_level), 15);

    enable = 1'b0;
    step(2);
    check("idle2_level",   int'(fifo_level), 0);
    check("idle2_s_ready", int'(s_ready),    0);

    // rate_div 9 -> 1 mid-period
    rate_div = 16'd9; enable = 1'b1;
    step(1);
    s_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_data = 16'(vals[i]);
      if (i == 3) rate_div = 16'd1;
      step(1);
    end
    s_valid = 1'b0;
    step(3);
    check("div_pre_level", int'(fifo_level), 6);
    step(1);
    check("div_tick10_dac",   int'(dac_din),    11);
    check("div_tick10_level", int'(fifo_level), 5);
    step(1);
    check("div_hold_dac", int'(dac_din), 11);
    step(1);
    check("div_tick2_dac", int'(dac_din), 22);
    step(2);
    check("div_tick3_dac", int'(dac_din), 33);
    step(2);
    check("div_tick4_dac", int'(dac_din),    -5000);
    check("div_level",     int'(fifo_level), 2);
    check("div_s_ready",   int'(s_ready),    1);

    // asynchronous reset mid-cycle
    #2;
    reset = 1'b1;
    #1;
    check("arst_dac",      int'(dac_din),    0);
    check("arst_s_ready",  int'(s_ready),    0);
    check("arst_level",    int'(fifo_level), 0);
    check("arst_underrun", int'(underrun),   0);
    step(2);
    reset = 1'b0;
    step(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
